// File: rtl/mdu_pkg.sv
// Shared encodings and default widths for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int MDU_DATA_WIDTH  = 32;
  localparam int MDU_COUNT_WIDTH = 6;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_CALC   = 2'b01,
    S_FINISH = 2'b10
  } state_e;

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 step: shift-add multiply or restoring divide on magnitudes.
// Purely combinational; no latency and no handshake.
module mdu_iter_step
  import mdu_pkg::*;
#(
  parameter int Data_Width = MDU_DATA_WIDTH
) (
  input  logic                  is_div,
  input  logic [Data_Width-1:0] part_hi,
  input  logic [Data_Width-1:0] part_lo,
  input  logic [Data_Width-1:0] operand,
  output logic [Data_Width-1:0] next_hi,
  output logic [Data_Width-1:0] next_lo,
  output logic                  q_bit
);

  logic [Data_Width:0]   sum;
  logic [Data_Width:0]   shifted;
  logic [Data_Width-1:0] diff;

  always_comb begin
    sum     = {1'b0, part_hi} + (part_lo[0] ? {1'b0, operand} : '0);
    shifted = {part_hi, part_lo[Data_Width-1]};
    // Remainder stays below the divisor, so the low bits of the difference are exact.
    diff    = shifted[Data_Width-1:0] - operand;
    q_bit   = 1'b0;
    next_hi = sum[Data_Width:1];
    next_lo = {sum[0], part_lo[Data_Width-1:1]};
    if (is_div) begin
      q_bit   = (shifted >= {1'b0, operand});
      next_hi = q_bit ? diff : shifted[Data_Width-1:0];
      next_lo = {part_lo[Data_Width-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO; result Data_Width+1 edges after Start.
// No backpressure on Start: it is simply ignored while Busy, and the pipeline stalls on Busy.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int Data_Width  = MDU_DATA_WIDTH,
  parameter int Count_Width = MDU_COUNT_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start,
  input  logic [1:0]            Op,
  input  logic [Data_Width-1:0] SrcA,
  input  logic [Data_Width-1:0] SrcB,
  input  logic                  WriteHI,
  input  logic                  WriteLO,
  input  logic [Data_Width-1:0] WD,
  output logic [Data_Width-1:0] HI,
  output logic [Data_Width-1:0] LO,
  output logic                  Busy,
  output logic                  Done
);

  state_e                  state, state_nxt;
  logic [Count_Width-1:0]  cnt;
  logic                    is_div_q, neg_res_q, neg_rem_q, div_zero_q;
  logic [Data_Width-1:0]   opnd_q, acc_hi, acc_lo, hi_q, lo_q;
  logic                    done_q;
  logic [Data_Width-1:0]   step_hi, step_lo;
  logic                    q_bit;
  op_e                     op_in;
  logic                    in_div, in_signed, sign_a, sign_b;
  logic [Data_Width-1:0]   abs_a, abs_b;
  logic [2*Data_Width-1:0] prod;
  logic [Data_Width-1:0]   res_hi, res_lo;

  assign op_in     = op_e'(Op);
  assign in_div    = (op_in == OP_DIV) || (op_in == OP_DIVU);
  assign in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign sign_a    = in_signed && SrcA[Data_Width-1];
  assign sign_b    = in_signed && SrcB[Data_Width-1];
  assign abs_a     = sign_a ? -SrcA : SrcA;
  assign abs_b     = sign_b ? -SrcB : SrcB;

  mdu_iter_step #(.Data_Width(Data_Width)) u_step (
    .is_div  (is_div_q),
    .part_hi (acc_hi),
    .part_lo (acc_lo),
    .operand (opnd_q),
    .next_hi (step_hi),
    .next_lo (step_lo),
    .q_bit   (q_bit)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (Start) state_nxt = S_CALC;
      S_CALC:   if (cnt == Count_Width'(Data_Width - 1)) state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Sign correction; a zero divisor leaves |A| as remainder, so HI comes back as SrcA.
  always_comb begin
    prod = {acc_hi, acc_lo};
    if (neg_res_q) prod = -prod;
    res_hi = prod[2*Data_Width-1:Data_Width];
    res_lo = prod[Data_Width-1:0];
    if (is_div_q) begin
      res_hi = neg_rem_q ? -acc_hi : acc_hi;
      res_lo = div_zero_q ? '1 : (neg_res_q ? -acc_lo : acc_lo);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt        <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      opnd_q     <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (WriteHI) hi_q <= WD;
          if (WriteLO) lo_q <= WD;
          if (Start) begin
            cnt        <= '0;
            is_div_q   <= in_div;
            neg_res_q  <= sign_a ^ sign_b;
            neg_rem_q  <= sign_a;
            div_zero_q <= in_div && (SrcB == '0);
            acc_hi     <= '0;
            opnd_q     <= in_div ? abs_b : abs_a;
            acc_lo     <= in_div ? abs_a : abs_b;
          end
        end
        S_CALC: begin
          cnt    <= cnt + 1'b1;
          acc_hi <= step_hi;
          acc_lo <= is_div_q ? {step_lo[Data_Width-1:1], q_bit} : step_lo;
        end
        S_FINISH: begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign Done = done_q;
  assign Busy = (state != S_IDLE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model with cycle countdown, directed and random stimulus.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        CLK, RST, Start, WriteHI, WriteLO, Busy, Done;
  logic [1:0]  Op;
  logic [31:0] SrcA, SrcB, WD, HI, LO;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // Reference model state
  logic [31:0] m_hi = 0, m_lo = 0;
  logic        m_done = 0;
  logic [63:0] m_pend = 0;
  int          m_rem = 0;

  mult_div_unit dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
    .WriteHI(WriteHI), .WriteLO(WriteLO), .WD(WD), .HI(HI), .LO(LO),
    .Busy(Busy), .Done(Done)
  );

  initial CLK = 0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int          ia, ib;
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, res;
    ia = a; ib = b;
    sa = ia; sb = ib;
    ua = {32'b0, a}; ub = {32'b0, b};
    if (op == 2'b00) res = sa * sb;
    else if (op == 2'b01) res = ua * ub;
    else if (b == 0) res = {a, 32'hFFFF_FFFF};
    else begin
      if (op == 2'b10) begin q = sa / sb; r = sa % sb; end
      else begin q = longint'(ua / ub); r = longint'(ua % ub); end
      res = {r[31:0], q[31:0]};
    end
    return res;
  endfunction

  // Model: accepted op completes 33 edges later; HI/LO writes only when idle.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_hi <= 0; m_lo <= 0; m_done <= 0; m_rem <= 0;
    end else begin
      m_done <= 0;
      if (m_rem != 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_hi   <= m_pend[63:32];
          m_lo   <= m_pend[31:0];
          m_done <= 1;
        end
      end else begin
        if (WriteHI) m_hi <= WD;
        if (WriteLO) m_lo <= WD;
        if (Start) begin
          m_pend <= ref_result(Op, SrcA, SrcB);
          m_rem  <= 33;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("cyc_hi", {32'b0, HI}, {32'b0, m_hi});
      chk("cyc_lo", {32'b0, LO}, {32'b0, m_lo});
      chk("cyc_busy", {63'b0, Busy}, {63'b0, (m_rem != 0)});
      chk("cyc_done", {63'b0, Done}, {63'b0, m_done});
    end
  end

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input bit interfere, input string nm);
    int cyc;
    @(posedge CLK); #2;
    Start = 1; Op = op; SrcA = a; SrcB = b;
    @(posedge CLK); #2;
    Start = 0; SrcA = $urandom; SrcB = $urandom;
    cyc = 0;
    while (!Done && cyc < 100) begin
      @(posedge CLK); #2;
      cyc++;
      Start = 0; WriteLO = 0;
      if (interfere && cyc == 10) begin
        Start = 1; Op = OP_MULT; SrcA = 5; SrcB = 9; WriteLO = 1; WD = 32'hABCD;
      end
    end
    chk({nm, "_latency"}, 64'(cyc), 64'd33);
    chk({nm, "_busy_at_done"}, {63'b0, Busy}, 64'd0);
    chk({nm, "_hi"}, {32'b0, HI}, {32'b0, exp_hi});
    chk({nm, "_lo"}, {32'b0, LO}, {32'b0, exp_lo});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return $urandom % 20;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1; Start = 0; Op = 0; SrcA = 0; SrcB = 0; WriteHI = 0; WriteLO = 0; WD = 0;
    #1 RST = 0;
    #2;
    chk("rst_hi", {32'b0, HI}, 64'd0);
    chk("rst_lo", {32'b0, LO}, 64'd0);
    chk("rst_busy", {63'b0, Busy}, 64'd0);
    chk("rst_done", {63'b0, Done}, 64'd0);
    @(posedge CLK); #2;
    RST = 1; chk_en = 1;

    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, "multu_max");
    do_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, "mult_neg");
    do_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         0, "mult_min");
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, "div_neg");
    do_op(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        0, "divu");
    do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 0, "div_ovf");
    do_op(OP_DIVU,  32'h1234,      32'h0,         32'h1234,      32'hFFFF_FFFF, 0, "divu_zero");
    do_op(OP_DIV,   32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 0, "div_zero");
    do_op(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1, "busy_ignore");

    @(posedge CLK); #2;
    WriteHI = 1; WD = 32'h55;
    @(posedge CLK); #2;
    WriteHI = 0;
    chk("mthi", {32'b0, HI}, 64'h55);

    // Abort an operation partway through with an asynchronous reset.
    @(posedge CLK); #2;
    Start = 1; Op = OP_MULTU; SrcA = 32'hFFFF_FFFF; SrcB = 32'hFFFF_FFFF;
    @(posedge CLK); #2;
    Start = 0;
    repeat (10) @(posedge CLK);
    #2 RST = 0;
    #1;
    chk("abort_hi", {32'b0, HI}, 64'd0);
    chk("abort_lo", {32'b0, LO}, 64'd0);
    chk("abort_busy", {63'b0, Busy}, 64'd0);
    chk("abort_done", {63'b0, Done}, 64'd0);
    repeat (2) @(posedge CLK);
    #2 RST = 1;
    do_op(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 0, "after_abort");

    for (int i = 0; i < 3000; i++) begin
      @(posedge CLK); #2;
      Start   = ($urandom % 3 == 0);
      Op      = 2'($urandom);
      SrcA    = pick();
      SrcB    = pick();
      WriteHI = ($urandom % 6 == 0);
      WriteLO = ($urandom % 6 == 0);
      WD      = $urandom;
    end
    @(posedge CLK); #2;
    Start = 0; WriteHI = 0; WriteLO = 0;
    repeat (40) @(posedge CLK);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the register file: its SrcA/SrcB operands are the register file's RD1/RD2 read ports.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles, then holds the results in HI/LO for MFHI/MFLO.
- The controller stalls the pipeline on Busy. MTHI/MTLO write HI/LO directly.

Parameters:
- Data_Width, 32, operand/HI/LO width; must be even and ≥4.
- Count_Width, 6, iteration counter width; must satisfy 2^Count_Width > Data_Width.

Ports:
- CLK  input  1  clock, rising-edge.
- RST  input  1  asynchronous, active-low reset.
- Start  input  1  request an operation; sampled only in IDLE.
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start.
- SrcA  input  Data_Width  multiplicand/dividend (RD1).
- SrcB  input  Data_Width  multiplier/divisor (RD2).
- WriteHI  input  1  MTHI strobe.
- WriteLO  input  1  MTLO strobe.
- WD  input  Data_Width  MTHI/MTLO data.
- HI  output  Data_Width  high product / remainder.
- LO  output  Data_Width  low product / quotient.
- Busy  output  1  high whenever state ≠ IDLE.
- Done  output  1  one-cycle pulse when HI/LO are updated by an operation.

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE; HI=0, LO=0, Busy=0, Done=0; counter and internal operand registers cleared.
  - Reset mid-operation aborts it; no partial result reaches HI/LO.
- States: IDLE, CALC, FINISH.
- IDLE:
  - On an edge with Start=1: latch Op, |SrcA|, |SrcB|, sign flags and divide-by-zero flag; counter=0; go CALC.
  - Absolute values apply to signed ops only; unsigned ops latch raw values.
- CALC:
  - One radix-2 iteration per cycle: shift-add multiply or restoring divide.
  - Counter increments each edge; after the Data_Width-th iteration, go FINISH.
- FINISH:
  - Apply sign correction; write HI/LO; Done=1 for exactly the next cycle; go IDLE.
- Latency: with Start accepted at edge k, HI/LO are updated and Done rises at edge k+Data_Width+1 (edge k+33 at default).
  - Busy is 1 from edge k to edge k+Data_Width+1; Done and Busy are never high together.
  - A new Start is accepted in the same cycle that Done is high.
- Multiply results:
  - {HI,LO} = full 2·Data_Width-bit product.
  - Signed: product negated (two's complement, 64-bit) when signA ^ signB.
- Divide results:
  - LO = quotient, HI = remainder.
  - Signed: quotient negated when signA ^ signB; remainder takes the sign of the dividend (truncating division).
- Division boundary cases:
  - Overflow: signed -2^(W-1) / -1 → LO=0x80000000, HI=0.
  - Divide by zero (signed or unsigned): full latency; result LO=all ones, HI=SrcA unmodified.
- Handshake rules:
  - Start is ignored while Busy; Op/SrcA/SrcB need only be valid on the accepting edge.
- MTHI/MTLO:
  - In IDLE, WriteHI/WriteLO load WD into HI/LO on the edge.
  - Ignored while Busy (the controller must not issue them).
  - If Start and a write coincide in IDLE, the write happens and Start is also accepted; the operation result later overwrites.
- HI/LO hold their value at all other times. Outputs are registered directly; no combinational path from inputs to outputs.

Decomposition:
- Shared package mdu_pkg:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - state encoding: S_IDLE, S_CALC, S_FINISH;
  - default width constants.
- One sub-module is natural: mdu_iter_step, purely combinational. It takes the partial remainder/product, operand and mode, and produces the next partial value and quotient bit. The top level owns the FSM, counter, sign handling and HI/LO.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → at k+33: HI=0xFFFFFFFE, LO=0x00000001, Done pulse 1 cycle, Busy high cycles k..k+32.
- MULT -3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100 / 7 → LO=14, HI=2; DIV 0x80000000 / -1 → LO=0x80000000, HI=0.
- DIVU 0x1234 / 0 → LO=0xFFFFFFFF, HI=0x1234 after full latency.
- Start re-asserted mid-CALC with different operands → ignored, original result delivered. WriteLO 0xABCD while Busy → LO unchanged. WriteHI 0x55 in IDLE → HI=0x55 next edge.
- RST pulsed low at iteration 10 → HI=LO=0, Busy=0 immediately, no Done. New MULTU 2×3 afterwards → LO=6, HI=0.
